sram_ctrl_wide: RTL and testbench

Parametrised controller between the pipeline memory stage and the external asynchronous 16-bit SRAM. A host word of DATA_W bits is split into BEATS = DATA_W/SRAM_DW sequential SRAM accesses, each stretched to WAIT_CYC+1 clocks. The host sees a single-request ready/valid interface. Generalises the fixed 32-bit, fixed-timing controller with configurable width, configurable timing, per-beat write strobes and a read-valid pulse.

---
 rtl/sram_ctrl_wide_if.sv | 24 ++
 rtl/sram_ctrl_wide.sv | 151 +++++++++++++++
 tb/tb_sram_ctrl_wide.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_wide_if.sv
// Host-side request/response bundle for sram_ctrl_wide.
// The host (master) issues single read or write requests and sees a
// ready/valid style handshake; the controller (slave) answers.
interface sram_ctrl_wide_if #(
    parameter int DATA_W = 32
);
    logic              rd_en;
    logic              wr_en;
    logic [31:0]       address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              rd_valid;
    logic              ready;

    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, rd_valid, ready
    );

    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, rd_valid, ready
    );
endinterface

// File: rtl/sram_ctrl_wide.sv
// Wide-word controller for an external asynchronous SRAM.
// One host word is moved as BEATS consecutive SRAM accesses, lowest slice
// first, each access held for WAIT_CYC+1 clocks. Write enable is released
// on the last clock of every beat so address and data are held past the
// rising edge of WE_N.
module sram_ctrl_wide #(
    parameter int DATA_W   = 32,
    parameter int SRAM_DW  = 16,
    parameter int SRAM_AW  = 18,
    parameter int WAIT_CYC = 2
) (
    input  logic               clk,
    input  logic               rst,
    sram_ctrl_wide_if.slave    host,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_WE_N
);
    localparam int BEATS  = DATA_W / SRAM_DW;
    localparam int SHIFT  = $clog2(DATA_W / 8);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CYC_W  = $clog2(WAIT_CYC + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [CYC_W-1:0]  LAST_CYC  = CYC_W'(WAIT_CYC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [BEAT_W-1:0]   beat_reg, beat_next;
    logic [CYC_W-1:0]    cyc_reg, cyc_next;
    logic                is_write_reg, is_write_next;
    logic [SRAM_AW-1:0]  addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [DATA_W-1:0]   rbuf_reg, rbuf_next;
    logic [DATA_W-1:0]   read_data_reg, read_data_next;

    logic                beat_end;
    logic                last_beat;
    logic                dq_drive;
    logic [DATA_W+SRAM_DW-1:0] read_cat;
    logic [DATA_W-1:0]   read_shift;

    assign beat_end  = (cyc_reg == LAST_CYC);
    assign last_beat = (beat_reg == LAST_BEAT);

    // Incoming slice enters at the top; after BEATS shifts the first slice
    // sits at the bottom, giving lowest-slice-first ordering.
    assign read_cat   = {SRAM_DQ, rbuf_reg} >> SRAM_DW;
    assign read_shift = read_cat[DATA_W-1:0];

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            beat_reg      <= '0;
            cyc_reg       <= '0;
            is_write_reg  <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rbuf_reg      <= '0;
            read_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            beat_reg      <= beat_next;
            cyc_reg       <= cyc_next;
            is_write_reg  <= is_write_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            rbuf_reg      <= rbuf_next;
            read_data_reg <= read_data_next;
        end
    end

    // Next-state logic: accept, step through beats and cycles, finish.
    always_comb begin
        state_next     = state_reg;
        beat_next      = beat_reg;
        cyc_next       = cyc_reg;
        is_write_next  = is_write_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        rbuf_next      = rbuf_reg;
        read_data_next = read_data_reg;

        case (state_reg)
            IDLE: begin
                if (host.rd_en || host.wr_en) begin
                    state_next    = ACCESS;
                    beat_next     = '0;
                    cyc_next      = '0;
                    // A simultaneous read and write request is a write.
                    is_write_next = host.wr_en;
                    // Host byte address -> word index -> first SRAM word;
                    // upper bits fall away, so accesses wrap in SRAM space.
                    addr_next     = SRAM_AW'((host.address >> SHIFT) * 32'(BEATS));
                    wdata_next    = host.write_data;
                end
            end
            ACCESS: begin
                if (!beat_end) begin
                    cyc_next = cyc_reg + 1'b1;
                end else begin
                    cyc_next   = '0;
                    wdata_next = wdata_reg >> SRAM_DW;
                    if (!is_write_reg) begin
                        rbuf_next = read_shift;
                    end
                    if (last_beat) begin
                        state_next = DONE;
                        // All slices land in read_data on the same edge.
                        if (!is_write_reg) begin
                            read_data_next = read_shift;
                        end
                    end else begin
                        beat_next = beat_reg + 1'b1;
                        addr_next = addr_reg + 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // SRAM strobes are decoded from registered state only.
    assign dq_drive  = (state_reg == ACCESS) && is_write_reg;
    assign SRAM_CE_N = (state_reg != ACCESS);
    assign SRAM_OE_N = !((state_reg == ACCESS) && !is_write_reg);
    assign SRAM_WE_N = !(dq_drive && !beat_end);
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_ADDR = addr_reg;
    assign SRAM_DQ   = dq_drive ? wdata_reg[SRAM_DW-1:0] : {SRAM_DW{1'bz}};

    assign host.ready     = (state_reg == IDLE);
    assign host.rd_valid  = (state_reg == DONE) && !is_write_reg;
    assign host.read_data = read_data_reg;
endmodule

// File: tb/tb_sram_ctrl_wide.sv
// Directed bench for sram_ctrl_wide: a default 32/16 instance driven from a
// vector table plus hand sequences, and a 64-bit, single-wait instance.
module tb_sram_ctrl_wide;
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance 0: defaults ----------------
    sram_ctrl_wide_if #(.DATA_W(32)) host0 ();
    wire  [15:0] dq0;
    logic [17:0] sram_addr0;
    logic ub_n0, lb_n0, ce_n0, oe_n0, we_n0;

    sram_ctrl_wide u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .host      (host0),
        .SRAM_DQ   (dq0),
        .SRAM_ADDR (sram_addr0),
        .SRAM_UB_N (ub_n0),
        .SRAM_LB_N (lb_n0),
        .SRAM_CE_N (ce_n0),
        .SRAM_OE_N (oe_n0),
        .SRAM_WE_N (we_n0)
    );

    // ---------------- instance 1: 64-bit, WAIT_CYC=1 ----------------
    sram_ctrl_wide_if #(.DATA_W(64)) host1 ();
    wire  [15:0] dq1;
    logic [17:0] sram_addr1;
    logic ub_n1, lb_n1, ce_n1, oe_n1, we_n1;

    sram_ctrl_wide #(.DATA_W(64), .SRAM_DW(16), .SRAM_AW(18), .WAIT_CYC(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .host      (host1),
        .SRAM_DQ   (dq1),
        .SRAM_ADDR (sram_addr1),
        .SRAM_UB_N (ub_n1),
        .SRAM_LB_N (lb_n1),
        .SRAM_CE_N (ce_n1),
        .SRAM_OE_N (oe_n1),
        .SRAM_WE_N (we_n1)
    );

    // ---------------- SRAM models ----------------
    logic [15:0] mem0 [0:(1<<18)-1];
    logic [15:0] mem1 [0:(1<<18)-1];
    logic        pre_en;
    logic [17:0] pre_addr;
    logic [15:0] pre_data;
    logic        tb_drv;
    logic [15:0] tb_pat;

    // Bench-side bus keeper pattern proves the controller has let go of DQ.
    assign dq0 = (!ce_n0 && !oe_n0) ? mem0[sram_addr0] : (tb_drv ? tb_pat : 16'bz);
    assign dq1 = (!ce_n1 && !oe_n1) ? mem1[sram_addr1] : 16'bz;

    // Model memories capture the bus while WE_N is low; preload port for setup.
    always @(posedge clk) begin
        if (pre_en) begin
            mem0[pre_addr] <= pre_data;
        end else if (!ce_n0 && !we_n0) begin
            mem0[sram_addr0] <= dq0;
        end
        if (!ce_n1 && !we_n1) begin
            mem1[sram_addr1] <= dq1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One operation on instance 0; call at a negedge. Monitors until ready
    // returns (bounded) and leaves inputs idle at that negedge.
    task automatic op0(input logic rd, input logic wr, input logic hold,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output int busy, output int rv_cnt, output int rv_at,
                       output int we_lo, output int oe_lo,
                       output logic [17:0] first_addr, output int hold_err);
        logic        we_prev;
        logic [17:0] addr_prev;
        busy = 0; rv_cnt = 0; rv_at = -1; we_lo = 0; oe_lo = 0;
        first_addr = '0; hold_err = 0;
        we_prev = 1'b1;
        addr_prev = sram_addr0;
        host0.rd_en = rd;
        host0.wr_en = wr;
        host0.address = addr;
        host0.write_data = wd;
        @(posedge clk);
        #1;
        if (!hold) begin
            host0.rd_en = 1'b0;
            host0.wr_en = 1'b0;
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (host0.ready) begin
                host0.rd_en = 1'b0;
                host0.wr_en = 1'b0;
                break;
            end
            if (busy == 0) first_addr = sram_addr0;
            if (sram_addr0 != addr_prev && !we_prev) hold_err++;
            if (host0.rd_valid) begin
                rv_cnt++;
                rv_at = busy;
            end
            if (!we_n0) we_lo++;
            if (!oe_n0) oe_lo++;
            we_prev = we_n0;
            addr_prev = sram_addr0;
            busy++;
        end
    endtask

    // One operation on instance 1 with per-cycle address / WE_N expectations.
    task automatic op1(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [63:0] wd, input logic [17:0] base,
                       output int busy, output int addr_err, output int we_err,
                       output int rv_cnt);
        busy = 0; addr_err = 0; we_err = 0; rv_cnt = 0;
        host1.rd_en = rd;
        host1.wr_en = wr;
        host1.address = addr;
        host1.write_data = wd;
        @(posedge clk);
        #1;
        host1.rd_en = 1'b0;
        host1.wr_en = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (host1.ready) break;
            if (c < 8) begin
                if (sram_addr1 != 18'(base + 18'(c / 2))) addr_err++;
                if (we_n1 !== (wr ? ((c % 2) == 1) : 1'b1)) we_err++;
            end
            if (host1.rd_valid) rv_cnt++;
            busy++;
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic        hold;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [17:0] exp_base;
        logic [31:0] exp_rdata;
        int          exp_rv;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int busy, rv_cnt, rv_at, we_lo, oe_lo, hold_err, addr_err, we_err;
        logic [17:0] first_addr;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 18'h00080, 32'h0000_0000, 0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0,         18'h00080, 32'hDEAD_BEEF, 1};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0,         18'h00010, 32'h2222_1111, 1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_0204, 32'h1234_5678, 18'h00102, 32'h2222_1111, 0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h0000_0204, 32'h0,         18'h00102, 32'h1234_5678, 1};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h00FF_FFFC, 32'hCAFE_F00D, 18'h3FFFE, 32'h1234_5678, 0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h00FF_FFFC, 32'h0,         18'h3FFFE, 32'hCAFE_F00D, 1};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h0000_0008, 32'h0BAD_C0DE, 18'h00004, 32'hCAFE_F00D, 0};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 32'h0000_0103, 32'h0,         18'h00080, 32'hDEAD_BEEF, 1};

        rst = 1'b1;
        tb_drv = 1'b0;
        tb_pat = 16'hA5C3;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        host0.rd_en = 1'b0; host0.wr_en = 1'b0; host0.address = '0; host0.write_data = '0;
        host1.rd_en = 1'b0; host1.wr_en = 1'b0; host1.address = '0; host1.write_data = '0;

        // Preload words read back by vector 2.
        @(negedge clk);
        pre_en = 1'b1; pre_addr = 18'h00010; pre_data = 16'h1111;
        @(negedge clk);
        pre_addr = 18'h00011; pre_data = 16'h2222;
        @(negedge clk);
        pre_en = 1'b0;

        // Reset values.
        tb_drv = 1'b1;
        #1;
        chk("rst_ready", host0.ready, 1);
        chk("rst_rd_valid", host0.rd_valid, 0);
        chk("rst_read_data", host0.read_data, 0);
        chk("rst_addr", sram_addr0, 0);
        chk("rst_strobes", {ce_n0, oe_n0, we_n0, ub_n0, lb_n0}, 5'b11100);
        chk("rst_dq_released", dq0, 16'hA5C3);
        tb_drv = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            op0(vecs[i].rd, vecs[i].wr, vecs[i].hold, vecs[i].addr, vecs[i].wdata,
                busy, rv_cnt, rv_at, we_lo, oe_lo, first_addr, hold_err);
            $display("op %0d rd=%0b wr=%0b hold=%0b addr=0x%08h wdata=0x%08h -> busy=%0d base=0x%05h read_data=0x%08h rv=%0d",
                     i, vecs[i].rd, vecs[i].wr, vecs[i].hold, vecs[i].addr, vecs[i].wdata,
                     busy, first_addr, host0.read_data, rv_cnt);
            chk($sformatf("v%0d_busy", i), busy, 7);
            chk($sformatf("v%0d_rv_cnt", i), rv_cnt, vecs[i].exp_rv);
            if (vecs[i].exp_rv != 0) chk($sformatf("v%0d_rv_at", i), rv_at, 6);
            chk($sformatf("v%0d_we_lo", i), we_lo, vecs[i].wr ? 4 : 0);
            chk($sformatf("v%0d_oe_lo", i), oe_lo, vecs[i].wr ? 0 : 6);
            chk($sformatf("v%0d_base", i), first_addr, vecs[i].exp_base);
            chk($sformatf("v%0d_addr_hold", i), hold_err, 0);
            chk($sformatf("v%0d_read_data", i), host0.read_data, vecs[i].exp_rdata);
            if (vecs[i].wr) begin
                chk($sformatf("v%0d_mem_lo", i), mem0[vecs[i].exp_base], vecs[i].wdata[15:0]);
                chk($sformatf("v%0d_mem_hi", i), mem0[vecs[i].exp_base + 18'd1], vecs[i].wdata[31:16]);
            end
            // Held requests must not start a second operation.
            @(negedge clk);
            chk($sformatf("v%0d_idle_ready", i), {host0.ready, ce_n0}, 2'b11);
            @(negedge clk);
            chk($sformatf("v%0d_idle_ce", i), {host0.ready, ce_n0}, 2'b11);
        end

        // Back-to-back: read accepted on the first IDLE cycle after the write.
        op0(1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h600D_CAFE,
            busy, rv_cnt, rv_at, we_lo, oe_lo, first_addr, hold_err);
        $display("b2b write addr=0x00000400 -> busy=%0d base=0x%05h", busy, first_addr);
        chk("b2b_wr_busy", busy, 7);
        chk("b2b_wr_base", first_addr, 18'h00200);
        op0(1'b1, 1'b0, 1'b0, 32'h0000_0400, 32'h0,
            busy, rv_cnt, rv_at, we_lo, oe_lo, first_addr, hold_err);
        $display("b2b read addr=0x00000400 -> busy=%0d read_data=0x%08h rv=%0d", busy, host0.read_data, rv_cnt);
        chk("b2b_rd_busy", busy, 7);
        chk("b2b_rd_data", host0.read_data, 32'h600D_CAFE);
        chk("b2b_rd_valid", rv_cnt, 1);

        // Reset during the third cycle of a write.
        @(negedge clk);
        host0.wr_en = 1'b1; host0.address = 32'h0000_0300; host0.write_data = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        host0.wr_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_we_low", we_n0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tb_drv = 1'b1;
        #1;
        $display("reset mid-write -> ready=%0b we_n=%0b read_data=0x%08h", host0.ready, we_n0, host0.read_data);
        chk("abort_we_n", we_n0, 1);
        chk("abort_ready", host0.ready, 1);
        chk("abort_read_data", host0.read_data, 0);
        chk("abort_rd_valid", host0.rd_valid, 0);
        chk("abort_dq_released", dq0, 16'hA5C3);
        tb_drv = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Wide instance: four beats of two clocks each.
        op1(1'b0, 1'b1, 32'h0000_0008, 64'h0123_4567_89AB_CDEF, 18'h00004,
            busy, addr_err, we_err, rv_cnt);
        $display("w64 write addr=0x00000008 -> busy=%0d addr_err=%0d we_err=%0d", busy, addr_err, we_err);
        chk("w64_busy", busy, 9);
        chk("w64_addr_seq", addr_err, 0);
        chk("w64_we_seq", we_err, 0);
        chk("w64_mem", {mem1[18'h7], mem1[18'h6], mem1[18'h5], mem1[18'h4]}, 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        op1(1'b0, 1'b1, 32'h00FF_FFF8, 64'h1122_3344_5566_7788, 18'h3FFFC,
            busy, addr_err, we_err, rv_cnt);
        $display("w64 write addr=0x00FFFFF8 -> busy=%0d addr_err=%0d", busy, addr_err);
        chk("w64_top_addr_seq", addr_err, 0);
        chk("w64_top_mem", {mem1[18'h3FFFF], mem1[18'h3FFFE], mem1[18'h3FFFD], mem1[18'h3FFFC]},
            64'h1122_3344_5566_7788);
        @(negedge clk);
        op1(1'b1, 1'b0, 32'h00FF_FFF8, 64'h0, 18'h3FFFC,
            busy, addr_err, we_err, rv_cnt);
        $display("w64 read addr=0x00FFFFF8 -> busy=%0d read_data=0x%016h rv=%0d", busy, host1.read_data, rv_cnt);
        chk("w64_rd_busy", busy, 9);
        chk("w64_rd_addr_seq", addr_err, 0);
        chk("w64_rd_we", we_err, 0);
        chk("w64_rd_data", host1.read_data, 64'h1122_3344_5566_7788);
        chk("w64_rd_valid", rv_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
